fetch_ctrl: RTL

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 113 +++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: sequences opcode/operand byte reads, PC strobes and opcode issue.
// Optional conditional jump (P_JZ) support is enabled by defining FETCH_COND_JUMP_EN.
module fetch_ctrl #(
  parameter logic [7:0] P_JMP = 8'h10,
  parameter logic [7:0] P_JZ  = 8'h11,
  parameter logic [7:0] P_HLT = 8'hFF
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_run,
  input  logic [7:0]  i_memData,
  input  logic        i_memValid,
  input  logic        i_zero,
  input  logic        i_opReady,
  output logic        o_memRead,
  output logic        o_pcIncr,
  output logic        o_pcLoad,
  output logic        o_pcNoe,
  output logic [15:0] o_pcData,
  output logic [7:0]  o_opcode,
  output logic        o_opValid,
  output logic        o_halted
);

  localparam int unsigned addr_w = 16;
  localparam int unsigned byte_w = 8;

`ifdef FETCH_COND_JUMP_EN
  localparam bit cond_en = 1'b1;
`else
  localparam bit cond_en = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH_OP, S_FETCH_LO, S_FETCH_HI, S_LOAD, S_ISSUE, S_HALT
  } state_t;

  state_t state_q, state_d;
  logic   jz_q;
  logic   is_jmp_c, is_jz_c, is_hlt_c;
  state_t resume_c;

  // State register; reset wins over every other input on the same edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state and strobe decode.
  always_comb begin
    state_d   = state_q;
    o_memRead = 1'b0;
    o_pcNoe   = 1'b1;
    o_pcIncr  = 1'b0;
    o_pcLoad  = 1'b0;
    o_opValid = 1'b0;
    o_halted  = 1'b0;
    is_jmp_c  = (i_memData == P_JMP);
    is_jz_c   = cond_en && (i_memData == P_JZ);
    is_hlt_c  = (i_memData == P_HLT);
    resume_c  = i_run ? S_FETCH_OP : S_IDLE;
    case (state_q)
      S_IDLE: if (i_run) state_d = S_FETCH_OP;
      S_FETCH_OP, S_FETCH_LO, S_FETCH_HI: begin
        o_memRead = 1'b1;
        o_pcNoe   = 1'b0;
        // A reset on this edge discards the byte, so the PC must not advance either.
        o_pcIncr  = i_memValid && !i_reset;
        if (i_memValid) begin
          case (state_q)
            S_FETCH_OP: begin
              if (is_jmp_c || is_jz_c) state_d = S_FETCH_LO;
              else if (is_hlt_c)       state_d = S_HALT;
              else                     state_d = S_ISSUE;
            end
            S_FETCH_LO: state_d = S_FETCH_HI;
            default:    state_d = (!jz_q || i_zero) ? S_LOAD : resume_c;
          endcase
        end
      end
      S_LOAD: begin
        o_pcLoad = 1'b1;
        state_d  = resume_c;
      end
      S_ISSUE: begin
        o_opValid = 1'b1;
        if (i_opReady) state_d = resume_c;
      end
      S_HALT:  o_halted = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  // Opcode and jump-target capture on accepted fetch bytes.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_pcData <= addr_w'(0);
      o_opcode <= byte_w'(0);
      jz_q     <= 1'b0;
    end else if (i_memValid) begin
      case (state_q)
        S_FETCH_OP: begin
          jz_q <= is_jz_c;
          if (!is_jmp_c && !is_jz_c && !is_hlt_c) o_opcode <= i_memData;
        end
        S_FETCH_LO: o_pcData[7:0]  <= i_memData;
        S_FETCH_HI: o_pcData[15:8] <= i_memData;
        default: ;
      endcase
    end
  end

endmodule
